// File: rtl/pll_reconfig_sequencer.sv
// pll_reconfig_sequencer: sequences a runtime PLL reconfiguration for the
// test controller. It holds the PLL in reset, then presents the word and
// strobes the trigger. It waits for lock with a timeout, lets the clock
// settle, and then selects the reconfigured clock.
// Optional build macro PLL_RECONFIG_RETRY_EN: adds up to three full
// re-sequences after a lock timeout and adds the retry_count output.
module pll_reconfig_sequencer #(
   parameter int unsigned PLL_DATA_WIDTH = 16,
   parameter int unsigned RST_CYCLES     = 4,
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned LOCK_TIMEOUT   = 50000,
   parameter int unsigned TIMER_WIDTH    = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      req_valid,
   input  logic [PLL_DATA_WIDTH-1:0] req_data,
   output logic                      req_ready,
   output logic                      busy,
   output logic                      cfg_done,
   output logic                      cfg_error,
   output logic                      pll_reset,
   output logic [PLL_DATA_WIDTH-1:0] pll_data,
   output logic                      pll_trigger,
   output logic                      pll_switch,
   input  logic                      pll_locked
`ifdef PLL_RECONFIG_RETRY_EN
   ,
   output logic [1:0]                retry_count
`endif
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_TRIG,
      S_WAIT_LOCK,
      S_SETTLE,
      S_DONE,
      S_FAIL
   } state_t;

   localparam logic [TIMER_WIDTH-1:0] RST_LOAD    = TIMER_WIDTH'(RST_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] LOCK_LOAD   = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
   localparam logic [TIMER_WIDTH-1:0] SETTLE_LOAD = TIMER_WIDTH'(SETTLE_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_ONE   = TIMER_WIDTH'(1);

   state_t                    state_q, state_d;
   logic [TIMER_WIDTH-1:0]    timer_q, timer_d;
   logic [PLL_DATA_WIDTH-1:0] data_q;
   logic                      init_q;
   logic                      done_q;
   logic                      error_q;
   logic                      switch_q;
   logic                      lock_meta_q;
   logic                      lock_sync_q;
   logic                      xfer;
`ifdef PLL_RECONFIG_RETRY_EN
   logic [1:0]                retry_q, retry_d;
`endif

   assign xfer = req_valid && req_ready;

   // State, shared down-counter and retry count registers
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         timer_q <= '0;
`ifdef PLL_RECONFIG_RETRY_EN
         retry_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
`ifdef PLL_RECONFIG_RETRY_EN
         retry_q <= retry_d;
`endif
      end
   end

   // Next-state and timer reload/decrement decisions
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
`ifdef PLL_RECONFIG_RETRY_EN
      retry_d = retry_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (xfer) begin
               state_d = S_RST;
               timer_d = RST_LOAD;
`ifdef PLL_RECONFIG_RETRY_EN
               retry_d = '0;
`endif
            end
         end
         S_RST: begin
            if (timer_q == '0) begin
               state_d = S_TRIG;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         S_TRIG: begin
            state_d = S_WAIT_LOCK;
            timer_d = LOCK_LOAD;
         end
         S_WAIT_LOCK: begin
            // Lock takes priority over a timeout that expires on the same cycle
            if (lock_sync_q) begin
               state_d = S_SETTLE;
               timer_d = SETTLE_LOAD;
            end else if (timer_q == '0) begin
`ifdef PLL_RECONFIG_RETRY_EN
               if (retry_q != 2'd3) begin
                  retry_d = retry_q + 2'd1;
                  state_d = S_RST;
                  timer_d = RST_LOAD;
               end else begin
                  state_d = S_FAIL;
               end
`else
               state_d = S_FAIL;
`endif
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         S_SETTLE: begin
            if (!lock_sync_q) begin
               state_d = S_WAIT_LOCK;
               timer_d = LOCK_LOAD;
            end else if (timer_q == '0) begin
               state_d = S_DONE;
            end else begin
               timer_d = timer_q - TIMER_ONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Two-flop lock synchroniser; flushed while the PLL is held in reset so a
   // stale lock from the previous configuration is never seen after trigger
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else if (state_q == S_RST) begin
         lock_meta_q <= 1'b0;
         lock_sync_q <= 1'b0;
      end else begin
         lock_meta_q <= pll_locked;
         lock_sync_q <= lock_meta_q;
      end
   end

   // Registered outputs: captured word, completion pulse, sticky error, clock select
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         init_q   <= 1'b0;
         data_q   <= '0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
         switch_q <= 1'b0;
      end else begin
         init_q <= 1'b1;
         done_q <= (state_q == S_DONE);
         if (xfer) begin
            data_q   <= req_data;
            error_q  <= 1'b0;
            switch_q <= 1'b0;
         end else begin
            if (state_q == S_FAIL) error_q  <= 1'b1;
            if (state_q == S_DONE) switch_q <= 1'b1;
         end
      end
   end

   // State-decoded outputs; init_q keeps PLL reset high and ready low until the first clock
   always_comb begin
      req_ready   = init_q && (state_q == S_IDLE);
      busy        = (state_q != S_IDLE);
      pll_reset   = !init_q || (state_q == S_RST);
      pll_trigger = (state_q == S_TRIG);
      pll_data    = data_q;
      cfg_done    = done_q;
      cfg_error   = error_q;
      pll_switch  = switch_q;
`ifdef PLL_RECONFIG_RETRY_EN
      retry_count = retry_q;
`endif
   end

endmodule

// File: tb/tb_pll_reconfig_sequencer.sv
// Self-checking bench for pll_reconfig_sequencer. It uses random words, random
// lock glitches, a busy-time request, a lock timeout and an asynchronous abort.
// Expectations come from a timeline model built from the sequencing rules.
module tb_pll_reconfig_sequencer;

   localparam int unsigned RSTC   = 4;
   localparam int unsigned SETC   = 16;
   localparam int unsigned TO     = 100;
   localparam int unsigned PERIOD = RSTC + 1 + TO;
`ifdef PLL_RECONFIG_RETRY_EN
   localparam int unsigned ATTEMPTS = 4;
`else
   localparam int unsigned ATTEMPTS = 1;
`endif
   localparam int FAIL_IDX = int'(ATTEMPTS * PERIOD + 1);

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0;
   logic [15:0] req_data = '0;
   logic        pll_locked = 1'b0;
   logic        req_ready, busy, cfg_done, cfg_error;
   logic        pll_reset, pll_trigger, pll_switch;
   logic [15:0] pll_data;
`ifdef PLL_RECONFIG_RETRY_EN
   logic [1:0]  retry_count;
`endif

   int checks = 0;
   int errors = 0;
   bit lockpat [0:1023];

   pll_reconfig_sequencer #(
      .PLL_DATA_WIDTH(16),
      .RST_CYCLES    (RSTC),
      .SETTLE_CYCLES (SETC),
      .LOCK_TIMEOUT  (TO),
      .TIMER_WIDTH   (16)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_ready  (req_ready),
      .busy       (busy),
      .cfg_done   (cfg_done),
      .cfg_error  (cfg_error),
      .pll_reset  (pll_reset),
      .pll_data   (pll_data),
      .pll_trigger(pll_trigger),
      .pll_switch (pll_switch),
      .pll_locked (pll_locked)
`ifdef PLL_RECONFIG_RETRY_EN
      ,
      .retry_count(retry_count)
`endif
   );

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // {req_ready, busy, cfg_done, cfg_error, pll_reset, pll_trigger, pll_switch}
   function automatic logic [6:0] obs_vec();
      return {req_ready, busy, cfg_done, cfg_error, pll_reset, pll_trigger, pll_switch};
   endfunction

   function automatic void lock_fill(input bit v);
      for (int i = 0; i < 1024; i++) lockpat[i] = v;
   endfunction

   // Index of the cfg_done sample, with lock at the pin described by lockpat.
   // Lock counts from the cycle after trigger; it reaches the FSM 2 cycles late.
   // cfg_done follows the first window of SETC+1 consecutive high samples,
   // plus one cycle for the done register.
   function automatic int exp_done_idx();
      for (int k = int'(RSTC) + 1; k < 900; k++) begin
         bit ok = 1'b1;
         for (int i = 0; i <= int'(SETC); i++) if (!lockpat[k + i]) ok = 1'b0;
         if (ok) return k + int'(SETC) + 3;
      end
      return 900;
   endfunction

   // One request; sample index k is taken just after the k-th edge counted from the transfer edge
   task automatic run_txn(input logic [15:0] data, input bit expect_fail,
                          input int max_cyc, input int inj_at);
      int d, n, sk;
      bit is_seq;
      logic [6:0] expv;
      d = expect_fail ? FAIL_IDX : exp_done_idx();
      n = (max_cyc > 0) ? max_cyc : d + 4;
      check_eq("ready_before_xfer", 32'(req_ready), 32'd1);
      req_valid  = 1'b1;
      req_data   = data;
      pll_locked = lockpat[0];
      for (int k = 0; k < n; k++) begin
         @(negedge clock);
         check_eq($sformatf("pll_data[%0d]", k), 32'(pll_data), 32'(data));
         sk     = expect_fail ? (k % int'(PERIOD)) : k;
         is_seq = expect_fail ? (k < int'(ATTEMPTS * PERIOD)) : 1'b1;
         expv   = {k >= d, k < d, !expect_fail && k == d, expect_fail && k >= d,
                   is_seq && sk < int'(RSTC), is_seq && sk == int'(RSTC),
                   !expect_fail && k >= d};
         check_eq($sformatf("trace[%0d]", k), 32'(obs_vec()), 32'(expv));
`ifdef PLL_RECONFIG_RETRY_EN
         check_eq($sformatf("retry_count[%0d]", k), 32'(retry_count),
                  expect_fail ? ((k / int'(PERIOD)) > 3 ? 32'd3 : 32'(k / int'(PERIOD))) : 32'd0);
`endif
         req_valid  = (inj_at > 0) && (k + 1 >= inj_at) && (k + 1 < inj_at + 3);
         req_data   = req_valid ? 16'h1111 : 16'($urandom);
         pll_locked = lockpat[k + 1];
      end
      req_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int pos, len, ng;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check_eq("in_reset", 32'(obs_vec()), 32'b0000100);
      check_eq("in_reset_data", 32'(pll_data), 32'd0);
      reset = 1'b0;
      #1 check_eq("rst_hold_before_edge", 32'(pll_reset), 32'd1);
      @(negedge clock);
      check_eq("after_release", 32'(obs_vec()), 32'b1000000);

      // Basic reconfiguration with lock already high
      lock_fill(1'b1);
      run_txn(16'hA5C3, 1'b0, 0, -1);

      // A request while busy is ignored; the same word afterwards is accepted
      run_txn(16'h2B7E, 1'b0, 0, 6);
      run_txn(16'h1111, 1'b0, 0, -1);

      // Lock drops for one cycle in the middle of settling
      lock_fill(1'b1);
      lockpat[12] = 1'b0;
      run_txn(16'h5A5A, 1'b0, 0, -1);

      // Lock never arrives
      lock_fill(1'b0);
      run_txn(16'($urandom), 1'b1, 0, -1);

      // Random lock glitches, random words, occasional busy-time requests
      for (int it = 0; it < 6; it++) begin
         lock_fill(1'b1);
         ng = int'($urandom_range(1, 3));
         for (int g = 0; g < ng; g++) begin
            pos = int'($urandom_range(5, 40));
            len = int'($urandom_range(1, 3));
            for (int i = 0; i < len; i++) lockpat[pos + i] = 1'b0;
         end
         run_txn(16'($urandom), 1'b0, 0, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 10)) : -1);
      end

      // Asynchronous reset while waiting for lock
      lock_fill(1'b0);
      run_txn(16'hC0DE, 1'b1, 50, -1);
      #2 reset = 1'b1;
      #1;
      check_eq("async_rst", 32'(obs_vec()), 32'b0000100);
      check_eq("async_rst_data", 32'(pll_data), 32'd0);
`ifdef PLL_RECONFIG_RETRY_EN
      check_eq("async_rst_retry", 32'(retry_count), 32'd0);
`endif
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check_eq("after_release2", 32'(obs_vec()), 32'b1000000);

      lock_fill(1'b1);
      run_txn(16'h0F0F, 1'b0, 0, -1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
